// File: rtl/grid_map_pkg.sv
// Shared constants, types and helpers for the 40x40 path-search cell map.
package grid_map_pkg;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 40;
  localparam int COORD_W    = 6;
  localparam int ADDR_W     = 11;
  localparam int CELLS      = GRID_W * GRID_H;
  localparam int MAX_STARVE = 8;
  localparam int STARVE_W   = 4;

  typedef logic [1:0]         cell_t;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  localparam cell_t CELL_FREE     = 2'd0;
  localparam cell_t CELL_OBSTACLE = 2'd1;
  localparam cell_t CELL_PATH     = 2'd2;
  localparam cell_t CELL_VISITED  = 2'd3;

  localparam coord_t               GRID_W_C     = coord_t'(GRID_W);
  localparam coord_t               GRID_H_C     = coord_t'(GRID_H);
  localparam addr_t                LAST_ADDR    = addr_t'(CELLS - 1);
  localparam logic [STARVE_W-1:0]  STARVE_LIMIT = STARVE_W'(MAX_STARVE);

  // Who owns the RAM port in the current cycle.
  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_DISP,
    REQ_SRCH,
    REQ_LOAD
  } req_id_t;

  typedef enum logic {
    ST_CLEAR,
    ST_ARB
  } arb_state_t;

  // y*40 + x built from shifts; only meaningful for in-range coordinates.
  function automatic addr_t cell_addr(input coord_t x, input coord_t y);
    return {y, 5'b00000} + {2'b00, y, 3'b000} + {5'b00000, x};
  endfunction

  function automatic logic in_grid(input coord_t x, input coord_t y);
    return (x < GRID_W_C) && (y < GRID_H_C);
  endfunction

endpackage

// File: rtl/map_ram_sp.sv
// Single-port 1600x2 cell RAM with registered read (read-before-write).
module map_ram_sp
  import grid_map_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        wdata,
  output logic [1:0]        rdata
);

  logic [1:0] mem [0:CELLS-1];
  logic [1:0] rdata_reg;

  // One access per cycle: optional write plus registered read of the same address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_reg <= mem[addr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/grid_map_arbiter.sv
// Cell-map owner: arbitrates display, search and loader onto one RAM port,
// and wipes the whole map to FREE after reset or on request.
module grid_map_arbiter
  import grid_map_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               disp_req,
  input  logic [COORD_W-1:0] disp_x,
  input  logic [COORD_W-1:0] disp_y,
  output logic               disp_gnt,
  output logic               disp_rvalid,
  output logic [1:0]         disp_rdata,
  input  logic               srch_req,
  input  logic               srch_we,
  input  logic [COORD_W-1:0] srch_x,
  input  logic [COORD_W-1:0] srch_y,
  input  logic [1:0]         srch_wdata,
  output logic               srch_gnt,
  output logic               srch_rvalid,
  output logic [1:0]         srch_rdata,
  input  logic               load_req,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic [1:0]         load_wdata,
  output logic               load_gnt,
  input  logic               clear_start,
  output logic               clear_busy,
  output logic               clear_done,
  output logic               oob_err
);

  // Control state
  arb_state_t          state_reg;
  addr_t               clr_addr_reg;
  logic                clear_busy_reg;
  logic                clear_done_reg;
  logic                rr_ptr_reg;       // 0: search wins the next contested turn
  logic [STARVE_W-1:0] starve_cnt_reg;

  // Read return path
  logic  disp_rvalid_reg;
  logic  srch_rvalid_reg;
  logic  oob_rd_reg;
  cell_t disp_hold_reg;
  cell_t srch_hold_reg;

  // Arbitration and access mux
  req_id_t sel;
  logic    sl_any;
  logic    starve_hit;
  logic    in_range;
  coord_t  acc_x;
  coord_t  acc_y;
  logic    acc_we;
  cell_t   acc_wdata;

  // RAM port
  logic  ram_we;
  addr_t ram_addr;
  cell_t ram_wdata;
  cell_t ram_rdata;
  cell_t rd_cell;

  assign sl_any     = srch_req | load_req;
  assign starve_hit = (starve_cnt_reg >= STARVE_LIMIT) && sl_any;

  // Pick the winner: display first unless it has starved search/loader long
  // enough, otherwise round-robin between search and loader.
  always_comb begin
    sel = REQ_NONE;
    if (state_reg == ST_ARB && !clear_start) begin
      if (disp_req && !starve_hit) begin
        sel = REQ_DISP;
      end else if (srch_req && (!load_req || !rr_ptr_reg)) begin
        sel = REQ_SRCH;
      end else if (load_req) begin
        sel = REQ_LOAD;
      end
    end
  end

  // Route the winning requester's fields onto the access bus.
  always_comb begin
    acc_x     = disp_x;
    acc_y     = disp_y;
    acc_we    = 1'b0;
    acc_wdata = CELL_FREE;
    case (sel)
      REQ_SRCH: begin
        acc_x     = srch_x;
        acc_y     = srch_y;
        acc_we    = srch_we;
        acc_wdata = srch_wdata;
      end
      REQ_LOAD: begin
        acc_x     = load_x;
        acc_y     = load_y;
        acc_we    = 1'b1;
        acc_wdata = load_wdata;
      end
      default: ;
    endcase
  end

  assign in_range = in_grid(acc_x, acc_y);

  // Drive the RAM: clear sweep owns it in CLEAR, otherwise only in-range grants touch it.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = CELL_FREE;
    if (state_reg == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_addr_reg;
    end else if (sel != REQ_NONE && in_range) begin
      ram_we    = acc_we;
      ram_addr  = cell_addr(acc_x, acc_y);
      ram_wdata = acc_wdata;
    end
  end

  map_ram_sp u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Clear sequencer: sweep all 1600 cells, then hand the port to the arbiter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_CLEAR;
      clr_addr_reg   <= '0;
      clear_busy_reg <= 1'b1;
      clear_done_reg <= 1'b0;
    end else begin
      clear_done_reg <= 1'b0;
      case (state_reg)
        ST_CLEAR: begin
          if (clr_addr_reg == LAST_ADDR) begin
            state_reg      <= ST_ARB;
            clr_addr_reg   <= '0;
            clear_busy_reg <= 1'b0;
            clear_done_reg <= 1'b1;
          end else begin
            clr_addr_reg   <= clr_addr_reg + 1'b1;
          end
        end
        ST_ARB: begin
          if (clear_start) begin
            state_reg      <= ST_CLEAR;
            clr_addr_reg   <= '0;
            clear_busy_reg <= 1'b1;
          end
        end
        default: begin
          state_reg      <= ST_CLEAR;
          clr_addr_reg   <= '0;
          clear_busy_reg <= 1'b1;
        end
      endcase
    end
  end

  // Fairness bookkeeping: round-robin pointer and display-streak counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg     <= 1'b0;
      starve_cnt_reg <= '0;
    end else begin
      case (sel)
        REQ_SRCH: rr_ptr_reg <= 1'b1;
        REQ_LOAD: rr_ptr_reg <= 1'b0;
        default:  ;
      endcase
      if (sel == REQ_SRCH || sel == REQ_LOAD || !sl_any || state_reg != ST_ARB) begin
        starve_cnt_reg <= '0;
      end else if (sel == REQ_DISP) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
    end
  end

  // Track read grants so data can be returned (or faked for off-grid reads) next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_rvalid_reg <= 1'b0;
      srch_rvalid_reg <= 1'b0;
      oob_rd_reg      <= 1'b0;
      disp_hold_reg   <= CELL_FREE;
      srch_hold_reg   <= CELL_FREE;
    end else begin
      disp_rvalid_reg <= (sel == REQ_DISP);
      srch_rvalid_reg <= (sel == REQ_SRCH) && !srch_we;
      oob_rd_reg      <= ((sel == REQ_DISP) || (sel == REQ_SRCH && !srch_we)) && !in_range;
      if (disp_rvalid_reg) begin
        disp_hold_reg <= rd_cell;
      end
      if (srch_rvalid_reg) begin
        srch_hold_reg <= rd_cell;
      end
    end
  end

  // Off-grid reads look like walls so the search never paths through them.
  assign rd_cell = oob_rd_reg ? CELL_OBSTACLE : ram_rdata;

  assign disp_gnt    = (sel == REQ_DISP);
  assign srch_gnt    = (sel == REQ_SRCH);
  assign load_gnt    = (sel == REQ_LOAD);
  assign oob_err     = (sel != REQ_NONE) && !in_range;
  assign disp_rvalid = disp_rvalid_reg;
  assign srch_rvalid = srch_rvalid_reg;
  assign disp_rdata  = disp_rvalid_reg ? rd_cell : disp_hold_reg;
  assign srch_rdata  = srch_rvalid_reg ? rd_cell : srch_hold_reg;
  assign clear_busy  = clear_busy_reg;
  assign clear_done  = clear_done_reg;

endmodule

// File: tb/tb_grid_map_arbiter.sv
// Self-checking bench for grid_map_arbiter: clear timing, directed vector
// table, starvation/round-robin sequences, and random traffic against a model.
module tb_grid_map_arbiter;

  localparam int W = 40;
  localparam int H = 40;
  localparam int STARVE = 8;
  localparam int WD = 0;
  localparam int WS = 1;
  localparam int WL = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       disp_req = 1'b0;
  logic [5:0] disp_x = '0, disp_y = '0;
  logic       disp_gnt, disp_rvalid;
  logic [1:0] disp_rdata;
  logic       srch_req = 1'b0, srch_we = 1'b0;
  logic [5:0] srch_x = '0, srch_y = '0;
  logic [1:0] srch_wdata = '0;
  logic       srch_gnt, srch_rvalid;
  logic [1:0] srch_rdata;
  logic       load_req = 1'b0;
  logic [5:0] load_x = '0, load_y = '0;
  logic [1:0] load_wdata = '0;
  logic       load_gnt;
  logic       clear_start = 1'b0;
  logic       clear_busy, clear_done, oob_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [1:0] mmem [0:W*H-1];
  int         m_run;        // display grants in a row while search/loader waited
  bit         m_srch_turn;  // search gets the next contested turn
  logic [1:0] m_dhold, m_shold;
  bit         exp_drv, exp_srv;

  always #5 clk = ~clk;

  grid_map_arbiter dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
    .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .srch_req(srch_req), .srch_we(srch_we), .srch_x(srch_x), .srch_y(srch_y),
    .srch_wdata(srch_wdata), .srch_gnt(srch_gnt), .srch_rvalid(srch_rvalid),
    .srch_rdata(srch_rdata),
    .load_req(load_req), .load_x(load_x), .load_y(load_y), .load_wdata(load_wdata),
    .load_gnt(load_gnt),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .oob_err(oob_err)
  );

  function automatic logic [2:0] gvec();
    return {disp_gnt, srch_gnt, load_gnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drop_reqs();
    disp_req = 1'b0;
    srch_req = 1'b0;
    load_req = 1'b0;
  endtask

  // Starts at posedge+1 with reset released; holds all requests during the sweep.
  task automatic run_clear(input int pulse_at, output int busy_n, output int done_n, output int gnt_n);
    busy_n = 0; done_n = 0; gnt_n = 0;
    disp_req = 1'b1; disp_x = 6'd1; disp_y = 6'd1;
    srch_req = 1'b1; srch_we = 1'b0; srch_x = 6'd2; srch_y = 6'd2;
    load_req = 1'b1; load_x = 6'd3; load_y = 6'd3; load_wdata = 2'd0;
    for (int n = 0; n < 2000; n++) begin
      clear_start = (n == pulse_at);
      #1;
      if (clear_done) done_n++;
      if (!clear_busy) begin
        drop_reqs();
        clear_start = 1'b0;
        @(posedge clk); #1;
        if (clear_done) done_n++;
        return;
      end
      busy_n++;
      if (gvec() != 3'b000) gnt_n++;
      @(posedge clk); #1;
    end
    drop_reqs();
    clear_start = 1'b0;
  endtask

  // Single-requester transaction; starts and ends at posedge+1.
  task automatic do_txn(input int who, input bit we, input logic [5:0] x, input logic [5:0] y,
                        input logic [1:0] wd, input logic [1:0] exp_rd, input bit exp_oob,
                        input string name);
    int n;
    logic [2:0] want;
    bit is_rd;
    want  = (who == WD) ? 3'b100 : (who == WS) ? 3'b010 : 3'b001;
    is_rd = (who == WD) || (who == WS && !we);
    drop_reqs();
    case (who)
      WD: begin disp_req = 1'b1; disp_x = x; disp_y = y; end
      WS: begin srch_req = 1'b1; srch_we = we; srch_x = x; srch_y = y; srch_wdata = wd; end
      default: begin load_req = 1'b1; load_x = x; load_y = y; load_wdata = wd; end
    endcase
    #1;
    n = 0;
    while (gvec() !== want && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check({name, " gnt"}, 32'(gvec()), 32'(want));
    check({name, " oob"}, 32'(oob_err), 32'(exp_oob));
    @(posedge clk); #1;
    drop_reqs();
    if (who == WD) begin
      check({name, " rvalid"}, 32'(disp_rvalid), 1);
      check({name, " rdata"}, 32'(disp_rdata), 32'(exp_rd));
      m_dhold = exp_rd;
    end else if (who == WS && !we) begin
      check({name, " rvalid"}, 32'(srch_rvalid), 1);
      check({name, " rdata"}, 32'(srch_rdata), 32'(exp_rd));
      m_shold = exp_rd;
    end else begin
      check({name, " no rvalid"}, 32'({disp_rvalid, srch_rvalid}), 0);
    end
    if (!is_rd && x < W && y < H) mmem[int'(y) * W + int'(x)] = wd;
    $display("txn %s who=%0d we=%0b x=%0d y=%0d wd=%0d exp_rd=%0d oob=%0b",
             name, who, !is_rd, x, y, wd, exp_rd, exp_oob);
  endtask

  function automatic logic [5:0] rand_coord();
    if ($urandom_range(0, 9) == 0) return 6'($urandom_range(40, 63));
    return 6'($urandom_range(0, 39));
  endfunction

  task automatic check_returns(input int c);
    check($sformatf("rnd%0d disp_rvalid", c), 32'(disp_rvalid), 32'(exp_drv));
    check($sformatf("rnd%0d srch_rvalid", c), 32'(srch_rvalid), 32'(exp_srv));
    check($sformatf("rnd%0d disp_rdata", c), 32'(disp_rdata), 32'(m_dhold));
    check($sformatf("rnd%0d srch_rdata", c), 32'(srch_rdata), 32'(m_shold));
  endtask

  typedef struct {
    int         who;
    bit         we;
    logic [5:0] x;
    logic [5:0] y;
    logic [1:0] wd;
    logic [1:0] exp_rd;
    bit         exp_oob;
    string      name;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_n, gnt_n;
    logic [2:0] exp_g;
    int cells[$];

    vecs[0]  = '{WL, 1'b1, 6'd5,  6'd7,  2'd1, 2'd0, 1'b0, "load_w_5_7"};
    vecs[1]  = '{WS, 1'b0, 6'd5,  6'd7,  2'd0, 2'd1, 1'b0, "srch_r_5_7"};
    vecs[2]  = '{WD, 1'b0, 6'd0,  6'd0,  2'd0, 2'd0, 1'b0, "disp_r_0_0"};
    vecs[3]  = '{WD, 1'b0, 6'd39, 6'd39, 2'd0, 2'd0, 1'b0, "disp_r_39_39"};
    vecs[4]  = '{WS, 1'b0, 6'd40, 6'd3,  2'd0, 2'd1, 1'b1, "srch_r_40_3"};
    vecs[5]  = '{WL, 1'b1, 6'd3,  6'd45, 2'd2, 2'd0, 1'b1, "load_w_3_45"};
    vecs[6]  = '{WS, 1'b0, 6'd3,  6'd5,  2'd0, 2'd0, 1'b0, "srch_r_3_5"};
    vecs[7]  = '{WS, 1'b1, 6'd10, 6'd20, 2'd3, 2'd0, 1'b0, "srch_w_10_20"};
    vecs[8]  = '{WD, 1'b0, 6'd10, 6'd20, 2'd0, 2'd3, 1'b0, "disp_r_10_20"};
    vecs[9]  = '{WS, 1'b1, 6'd10, 6'd20, 2'd2, 2'd0, 1'b0, "srch_w2_10_20"};
    vecs[10] = '{WS, 1'b0, 6'd10, 6'd20, 2'd0, 2'd2, 1'b0, "srch_r_10_20"};
    vecs[11] = '{WL, 1'b1, 6'd39, 6'd0,  2'd1, 2'd0, 1'b0, "load_w_39_0"};
    vecs[12] = '{WD, 1'b0, 6'd39, 6'd0,  2'd0, 2'd1, 1'b0, "disp_r_39_0"};
    vecs[13] = '{WD, 1'b0, 6'd0,  6'd1,  2'd0, 2'd0, 1'b0, "disp_r_0_1"};
    vecs[14] = '{WD, 1'b0, 6'd40, 6'd0,  2'd0, 2'd1, 1'b1, "disp_r_40_0"};
    vecs[15] = '{WS, 1'b0, 6'd63, 6'd63, 2'd0, 2'd1, 1'b1, "srch_r_63_63"};
    vecs[16] = '{WS, 1'b1, 6'd41, 6'd2,  2'd3, 2'd0, 1'b1, "srch_w_41_2"};
    vecs[17] = '{WD, 1'b0, 6'd1,  6'd3,  2'd0, 2'd0, 1'b0, "disp_r_1_3"};

    for (int i = 0; i < W * H; i++) mmem[i] = 2'd0;
    m_dhold = 2'd0; m_shold = 2'd0;

    // Reset state, with a request pending to prove nothing is granted
    disp_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset clear_busy", 32'(clear_busy), 1);
    check("reset clear_done", 32'(clear_done), 0);
    check("reset gnt", 32'(gvec()), 0);
    check("reset rvalid", 32'({disp_rvalid, srch_rvalid}), 0);
    check("reset rdata", 32'({disp_rdata, srch_rdata}), 0);
    check("reset oob_err", 32'(oob_err), 0);
    reset = 1'b0;

    // Power-up clear, with a clear_start pulse that must be ignored
    run_clear(100, busy_n, done_n, gnt_n);
    check("clear busy cycles", 32'(busy_n), 1600);
    check("clear_done pulses", 32'(done_n), 1);
    check("gnt during clear", 32'(gnt_n), 0);
    $display("txn clear busy=%0d done=%0d gnt=%0d", busy_n, done_n, gnt_n);

    // Search and loader contend with display idle: S,L,S,L
    srch_req = 1'b1; srch_we = 1'b1; srch_x = 6'd2; srch_y = 6'd2; srch_wdata = 2'd0;
    load_req = 1'b1; load_x = 6'd3; load_y = 6'd3; load_wdata = 2'd0;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_g = (i % 2 == 0) ? 3'b010 : 3'b001;
      check($sformatf("rr cycle %0d", i), 32'(gvec()), 32'(exp_g));
      $display("txn rr cycle=%0d gnt=%b", i, gvec());
      @(posedge clk); #1;
    end
    drop_reqs();
    @(posedge clk); #1;

    // All three held: D x8, S, D x8, L, repeating
    disp_req = 1'b1; disp_x = 6'd1; disp_y = 6'd1;
    srch_req = 1'b1; load_req = 1'b1;
    for (int i = 0; i < 36; i++) begin
      #1;
      case (i % 18)
        8:       exp_g = 3'b010;
        17:      exp_g = 3'b001;
        default: exp_g = 3'b100;
      endcase
      check($sformatf("starve cycle %0d", i), 32'(gvec()), 32'(exp_g));
      $display("txn starve cycle=%0d gnt=%b", i, gvec());
      @(posedge clk); #1;
    end
    drop_reqs();
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      do_txn(vecs[i].who, vecs[i].we, vecs[i].x, vecs[i].y, vecs[i].wd,
             vecs[i].exp_rd, vecs[i].exp_oob, vecs[i].name);
    end

    // Known arbitration state before random traffic: search favoured, no streak
    do_txn(WL, 1'b1, 6'd0, 6'd0, 2'd0, 2'd0, 1'b0, "load_sync");
    m_run = 0;
    m_srch_turn = 1'b1;
    exp_drv = 1'b0;
    exp_srv = 1'b0;

    // Random traffic against the model
    begin
      bit pd, ps, pl, swe;
      logic [5:0] dx, dy, sx, sy, lx, ly;
      logic [1:0] swd, lwd;
      int p;
      bit sl, inr;
      logic [5:0] ax, ay;
      pd = 0; ps = 0; pl = 0; swe = 0;
      dx = 0; dy = 0; sx = 0; sy = 0; lx = 0; ly = 0; swd = 0; lwd = 0;
      for (int c = 0; c < 600; c++) begin
        check_returns(c);
        if (!pd && $urandom_range(0, 2) == 0) begin pd = 1; dx = rand_coord(); dy = rand_coord(); end
        if (!ps && $urandom_range(0, 2) == 0) begin
          ps = 1; sx = rand_coord(); sy = rand_coord(); swe = 1'($urandom_range(0, 1)); swd = 2'($urandom_range(0, 3));
        end
        if (!pl && $urandom_range(0, 3) == 0) begin
          pl = 1; lx = rand_coord(); ly = rand_coord(); lwd = 2'($urandom_range(0, 3));
        end
        disp_req = pd; disp_x = dx; disp_y = dy;
        srch_req = ps; srch_we = swe; srch_x = sx; srch_y = sy; srch_wdata = swd;
        load_req = pl; load_x = lx; load_y = ly; load_wdata = lwd;
        #1;
        sl = ps | pl;
        if (pd && !(sl && m_run >= STARVE)) p = WD;
        else if (ps && pl) p = m_srch_turn ? WS : WL;
        else if (ps) p = WS;
        else if (pl) p = WL;
        else p = -1;
        exp_g = (p == WD) ? 3'b100 : (p == WS) ? 3'b010 : (p == WL) ? 3'b001 : 3'b000;
        ax = (p == WD) ? dx : (p == WS) ? sx : lx;
        ay = (p == WD) ? dy : (p == WS) ? sy : ly;
        inr = (ax < W) && (ay < H);
        check($sformatf("rnd%0d gnt", c), 32'(gvec()), 32'(exp_g));
        check($sformatf("rnd%0d oob", c), 32'(oob_err), 32'(p >= 0 && !inr));
        exp_drv = (p == WD);
        exp_srv = (p == WS) && !swe;
        if (p == WD) m_dhold = inr ? mmem[int'(ay) * W + int'(ax)] : 2'd1;
        if (p == WS && !swe) m_shold = inr ? mmem[int'(ay) * W + int'(ax)] : 2'd1;
        if (p == WS && swe && inr) mmem[int'(ay) * W + int'(ax)] = swd;
        if (p == WL && inr) mmem[int'(ay) * W + int'(ax)] = lwd;
        if (p == WS || p == WL) begin
          m_run = 0;
          m_srch_turn = (p == WL);
        end else if (!sl) begin
          m_run = 0;
        end else if (p == WD) begin
          m_run++;
        end
        if (p == WD) pd = 0;
        if (p == WS) ps = 0;
        if (p == WL) pl = 0;
        if (p >= 0) $display("txn rnd cyc=%0d who=%0d x=%0d y=%0d oob=%0b", c, p, ax, ay, !inr);
        @(posedge clk); #1;
      end
      drop_reqs();
      check_returns(600);
    end

    // clear_start mid-traffic, then reset part-way through the sweep
    for (int i = 0; i < W * H; i++) begin
      if (mmem[i] != 2'd0 && cells.size() < 6) cells.push_back(i);
    end
    disp_req = 1'b1; disp_x = 6'd1; disp_y = 6'd1;
    srch_req = 1'b1; srch_we = 1'b0; srch_x = 6'd2; srch_y = 6'd2;
    clear_start = 1'b1;
    #1;
    check("clear_start cycle gnt", 32'(gvec()), 0);
    @(posedge clk); #1;
    clear_start = 1'b0;
    drop_reqs();
    check("clear_start busy", 32'(clear_busy), 1);
    repeat (799) @(posedge clk);
    reset = 1'b1;
    #1;
    check("mid-clear reset busy", 32'(clear_busy), 1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    run_clear(-1, busy_n, done_n, gnt_n);
    check("reclear busy cycles", 32'(busy_n), 1600);
    check("reclear clear_done pulses", 32'(done_n), 1);
    check("reclear gnt", 32'(gnt_n), 0);
    $display("txn reclear busy=%0d done=%0d gnt=%0d", busy_n, done_n, gnt_n);
    for (int i = 0; i < W * H; i++) mmem[i] = 2'd0;

    do_txn(WS, 1'b0, 6'd5, 6'd7, 2'd0, 2'd0, 1'b0, "post_clear_5_7");
    do_txn(WD, 1'b0, 6'd10, 6'd20, 2'd0, 2'd0, 1'b0, "post_clear_10_20");
    do_txn(WS, 1'b0, 6'd39, 6'd0, 2'd0, 2'd0, 1'b0, "post_clear_39_0");
    foreach (cells[k]) begin
      do_txn((k % 2 == 0) ? WD : WS, 1'b0, 6'(cells[k] % W), 6'(cells[k] / W),
             2'd0, 2'd0, 1'b0, $sformatf("post_clear_cell%0d", cells[k]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
